// File: rtl/decoder_pkg.sv
// Shared condition-field types and one-hot constants for the binary-to-one-hot decoder.
package decoder_pkg;

  localparam int COND_W = 2;

  typedef logic [COND_W-1:0]      cond_sel_t;
  typedef logic [(1<<COND_W)-1:0] cond_onehot_t;

  // Condition-type vectors the control unit uses to gate conditional PC writes.
  localparam cond_onehot_t COND_T0 = 4'b0001;
  localparam cond_onehot_t COND_T1 = 4'b0010;
  localparam cond_onehot_t COND_T2 = 4'b0100;
  localparam cond_onehot_t COND_T3 = 4'b1000;

endpackage

// File: rtl/decoder_if.sv
// Select/decode bundle between a select source (master) and the decoder (slave).
interface decoder_if #(
  parameter int IN_W = 2
) ();

  localparam int OUT_W = 1 << IN_W;

  // No valid/ready: en qualifies sel on every cycle it is sampled, and dec/any
  // are the decoder's answer with no backpressure.
  logic             en;
  logic [IN_W-1:0]  sel;
  logic [OUT_W-1:0] dec;
  logic             any;

  modport master (output en, output sel, input dec, input any);
  modport slave  (input en, input sel, output dec, output any);

endinterface

// File: rtl/decoder_core.sv
// Purely combinational one-hot generator: one equality compare per output bit.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic                   en,
  input  logic [IN_W-1:0]        sel,
  output logic [(1<<IN_W)-1:0]   dec
);

  localparam int OUT_W = 1 << IN_W;

  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    assign dec[i] = en && (sel == IN_W'(i));
  end

endmodule

// File: rtl/decoder.sv
// Binary-to-one-hot decoder top. Define DECODER_REG_OUT_EN to register dec
// (1-cycle latency, synchronous active-high reset); otherwise fully combinational.
module decoder
  import decoder_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic     clk,
  input  logic     rst,
  decoder_if.slave bus
);

  localparam int OUT_W = 1 << IN_W;

  logic [OUT_W-1:0] dec_c;
  logic [OUT_W-1:0] dec_o;

  decoder_core #(.IN_W(IN_W)) u_core (
    .en  (bus.en),
    .sel (bus.sel),
    .dec (dec_c)
  );

`ifdef DECODER_REG_OUT_EN
  // Reset wins over a simultaneous enable so the pipeline boundary comes up quiet.
  always_ff @(posedge clk) begin
    if (rst) dec_o <= '0;
    else     dec_o <= dec_c;
  end
`else
  // Clock and reset exist only for the registered build.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign dec_o          = dec_c;
`endif

  // any is taken from the final dec so it shares its timing in both builds.
  assign bus.dec = dec_o;
  assign bus.any = |dec_o;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder (IN_W=2 and IN_W=3 instances); honours DECODER_REG_OUT_EN.
module tb_decoder;
  import decoder_pkg::*;

`ifdef DECODER_REG_OUT_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  decoder_if #(.IN_W(2)) bus2 ();
  decoder_if #(.IN_W(3)) bus3 ();

  decoder #(.IN_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  decoder #(.IN_W(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: one-hot is simply 1 shifted left by the select code
  function automatic logic [3:0] ref4(input logic e, input logic [1:0] s, input logic r);
    if (REG && r) return 4'b0;
    return e ? (4'b1 << s) : 4'b0;
  endfunction

  function automatic logic [7:0] ref8(input logic e, input logic [2:0] s, input logic r);
    if (REG && r) return 8'b0;
    return e ? (8'b1 << s) : 8'b0;
  endfunction

  // driver: apply inputs at negedge, then wait to the sampling point
  task automatic drive(input logic r, input logic e, input logic [1:0] s,
                       input logic e3, input logic [2:0] s3);
    @(negedge clk);
    rst      = r;
    bus2.en  = e;
    bus2.sel = s;
    bus3.en  = e3;
    bus3.sel = s3;
    if (REG) begin
      @(posedge clk);
      #1;
    end else begin
      #1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 2'd2, 1'b0, 3'd0);
      exp = ref4(1'b1, 2'd2, 1'b1);
      vectors++;
      if (bus2.dec !== exp || bus2.any !== (exp != 0)) begin
        miscompares++;
        $display("FAIL reset: dec=%b any=%b expected dec=%b any=%b", bus2.dec, bus2.any, exp, exp != 0);
      end
    end
  endtask

  task automatic test_sweep();
    logic [3:0] tbl [4];
    tbl[0] = COND_T0; tbl[1] = COND_T1; tbl[2] = COND_T2; tbl[3] = COND_T3;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'(i), 1'b0, 3'd0);
      vectors++;
      if (bus2.dec !== tbl[i] || bus2.any !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep sel=%0d: dec=%b any=%b expected dec=%b any=1", i, bus2.dec, bus2.any, tbl[i]);
      end
    end
  endtask

  task automatic test_enable();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 3'd0);
    vectors++;
    if (bus2.dec !== 4'b0000 || bus2.any !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_off: dec=%b any=%b expected dec=0000 any=0", bus2.dec, bus2.any);
    end
    drive(1'b0, 1'b1, 2'b10, 1'b0, 3'd0);
    vectors++;
    if (bus2.dec !== 4'b0100 || bus2.any !== 1'b1) begin
      miscompares++;
      $display("FAIL enable_on: dec=%b any=%b expected dec=0100 any=1", bus2.dec, bus2.any);
    end
  endtask

  task automatic test_latency();
    logic [3:0] pre;
    drive(1'b1, 1'b0, 2'd0, 1'b0, 3'd0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b0; bus2.en = 1'b1; bus2.sel = 2'd3;
    #1;
    pre = REG ? 4'b0000 : 4'b1000;
    vectors++;
    if (bus2.dec !== pre) begin
      miscompares++;
      $display("FAIL latency_pre_edge: dec=%b expected %b", bus2.dec, pre);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus2.dec !== 4'b1000 || bus2.any !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_post_edge: dec=%b any=%b expected dec=1000 any=1", bus2.dec, bus2.any);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    drive(1'b1, 1'b1, 2'd1, 1'b0, 3'd0);
    exp = ref4(1'b1, 2'd1, 1'b1);
    vectors++;
    if (bus2.dec !== exp || bus2.any !== (exp != 0)) begin
      miscompares++;
      $display("FAIL reset_mid: dec=%b any=%b expected dec=%b", bus2.dec, bus2.any, exp);
    end
    drive(1'b0, 1'b1, 2'd1, 1'b0, 3'd0);
    vectors++;
    if (bus2.dec !== 4'b0010 || bus2.any !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: dec=%b any=%b expected dec=0010 any=1", bus2.dec, bus2.any);
    end
  endtask

  task automatic test_wide();
    drive(1'b0, 1'b0, 2'd0, 1'b1, 3'd7);
    vectors++;
    if (bus3.dec !== 8'b1000_0000 || bus3.any !== 1'b1) begin
      miscompares++;
      $display("FAIL wide_sel7: dec=%b any=%b expected dec=10000000 any=1", bus3.dec, bus3.any);
    end
    drive(1'b0, 1'b0, 2'd0, 1'b1, 3'd0);
    vectors++;
    if (bus3.dec !== 8'b0000_0001 || bus3.any !== 1'b1) begin
      miscompares++;
      $display("FAIL wide_sel0: dec=%b any=%b expected dec=00000001 any=1", bus3.dec, bus3.any);
    end
  endtask

  task automatic test_random();
    logic       r, e, e3;
    logic [1:0] s;
    logic [2:0] s3;
    logic [3:0] exp4;
    logic [7:0] exp8;
    for (int n = 0; n < 1000; n++) begin
      r  = ($urandom_range(0, 19) == 0);
      e  = 1'($urandom_range(0, 1));
      e3 = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      s3 = 3'($urandom_range(0, 7));
      drive(r, e, s, e3, s3);
      exp4 = ref4(e, s, r);
      exp8 = ref8(e3, s3, r);
      vectors++;
      if (bus2.dec !== exp4 || bus2.any !== (exp4 != 0) ||
          !$onehot0(bus2.dec) || ($onehot(bus2.dec) !== (e && !(REG && r)))) begin
        miscompares++;
        $display("FAIL random4 n=%0d r=%b en=%b sel=%0d: dec=%b any=%b expected dec=%b",
                 n, r, e, s, bus2.dec, bus2.any, exp4);
      end
      vectors++;
      if (bus3.dec !== exp8 || bus3.any !== (exp8 != 0) || bus3.any !== (|bus3.dec)) begin
        miscompares++;
        $display("FAIL random8 n=%0d r=%b en=%b sel=%0d: dec=%b any=%b expected dec=%b",
                 n, r, e3, s3, bus3.dec, bus3.any, exp8);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus2.en     = 1'b0;
    bus2.sel    = '0;
    bus3.en     = 1'b0;
    bus3.sel    = '0;
    test_reset();
    test_sweep();
    test_enable();
    test_latency();
    test_reset_mid();
    test_wide();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
